// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared pipeline constants used by the instruction-fetch stage.
//   NOP_INSTRUCTION  : word inserted when a wrong-path slot is flushed
//   HALT_INSTRUCTION : word that stops fetch when halt detection is built in
//   PC_INCREMENT     : byte distance between consecutive instructions
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;
  localparam int unsigned PC_INCREMENT     = 4;

endpackage

// File: rtl/fetch_stage_instruction_memory.sv
// instruction_memory
//   Word-addressed instruction store with an independent write port used by
//   the debug loader. The read port returns the addressed word directly; the
//   fetch stage samples it into its output register on the advancing edge, so
//   the fetch as a whole is a synchronous read. Contents are never reset.
// Ports:
//   clk_i    : clock for the write port
//   we_i     : write strobe
//   waddr_i  : write word address
//   wdata_i  : write data
//   raddr_i  : read word address
//   rdata_o  : word at raddr_i
module instruction_memory #(
  parameter int unsigned NB_DATA      = 32,
  parameter int unsigned NB_MEM_DEPTH = 256,
  parameter int unsigned NB_ADDR      = 8
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [NB_ADDR-1:0] waddr_i,
  input  logic [NB_DATA-1:0] wdata_i,
  input  logic [NB_ADDR-1:0] raddr_i,
  output logic [NB_DATA-1:0] rdata_o
);

  logic [NB_DATA-1:0] mem_q [NB_MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC and
//   the instruction memory and registers the instruction / PC+4 pair for
//   decode. Jump has priority over branch; a redirect flushes the fetched
//   slot with a NOP. The memory load port only commits while i_valid is low.
//   Optional feature macro: FETCH_HALT_DETECT_EN (sticky halt on 32'hFFFFFFFF).
// Ports:
//   i_clock, i_reset          : clock, synchronous active-high reset
//   i_valid, i_stall          : run enable, hazard stall
//   i_jump, i_jump_addr       : jump redirect and target byte address
//   i_branch_taken, i_branch_addr : branch redirect and target byte address
//   i_mem_write_*             : program load port (word address)
//   o_instruction, o_pc_next  : registered instruction and its PC+4
//   o_pc                      : current program counter
//   o_halt                    : sticky halt flag
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned NB_DATA      = 32,
  parameter int unsigned NB_MEM_DEPTH = 256,
  parameter int unsigned NB_ADDR      = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_stall,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_jump_addr,
  input  logic               i_branch_taken,
  input  logic [NB_DATA-1:0] i_branch_addr,
  input  logic               i_mem_write_enable,
  input  logic [NB_ADDR-1:0] i_mem_write_addr,
  input  logic [NB_DATA-1:0] i_mem_write_data,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pc_next,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_halt
);

  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [NB_DATA-1:0] pc_next_q, pc_next_d;
  logic               halt_q;
  logic               fetch_halt;
  logic               adv;
  logic               redirect;
  logic [NB_DATA-1:0] target;
  logic [NB_DATA-1:0] pc_plus4;
  logic [NB_DATA-1:0] rd_word;

  assign adv      = i_valid & ~i_stall & ~halt_q;
  assign redirect = i_jump | i_branch_taken;
  assign target   = i_jump ? i_jump_addr : i_branch_addr;
  assign pc_plus4 = pc_q + NB_DATA'(PC_INCREMENT);

  // Upper PC bits are dropped, so fetch addresses wrap modulo the depth.
  instruction_memory #(
    .NB_DATA      (NB_DATA),
    .NB_MEM_DEPTH (NB_MEM_DEPTH),
    .NB_ADDR      (NB_ADDR)
  ) u_imem (
    .clk_i   (i_clock),
    .we_i    (i_mem_write_enable & ~i_valid),
    .waddr_i (i_mem_write_addr),
    .wdata_i (i_mem_write_data),
    .raddr_i (pc_q[NB_ADDR+1:2]),
    .rdata_o (rd_word)
  );

`ifdef FETCH_HALT_DETECT_EN
  logic halt_d;

  assign fetch_halt = (rd_word == NB_DATA'(HALT_INSTRUCTION));

  always_comb begin
    halt_d = halt_q;
    if (adv && !redirect && fetch_halt) begin
      halt_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end
`else
  assign fetch_halt = 1'b0;
  assign halt_q     = 1'b0;
`endif

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    if (adv) begin
      if (redirect) begin
        // Wrong-path slot becomes a NOP; o_pc_next keeps its old value.
        pc_d    = target;
        instr_d = NB_DATA'(NOP_INSTRUCTION);
      end else begin
        instr_d   = rd_word;
        pc_next_d = pc_plus4;
        if (!fetch_halt) begin
          pc_d = pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc_q      <= '0;
      instr_q   <= '0;
      pc_next_q <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_instruction = instr_q;
  assign o_pc_next     = pc_next_q;
  assign o_halt        = halt_q;

endmodule
